// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Purpose  : Shared types and constants for the memory-port arbiter and the
//            IFU/LSU that talk to it.
// Contents : state_t  - arbiter FSM states (IDLE, ISSUE, WAIT)
//            owner_t  - transaction owner (OWN_IF, OWN_LS)
//            ADDR_W_DEF / DATA_W_DEF - default bus widths
//            tcnt_width() - timeout counter width for a given limit
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Counter is never narrower than 8 bits, and wide enough to hold the limit.
  function automatic int tcnt_width(input int limit);
    return (limit < 256) ? 8 : $clog2(limit + 1);
  endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_grant_sel.sv
`default_nettype none
// ============================================================================
// Module   : arb_grant_sel
// Purpose  : Combinational grant selection between the fetch (IF) and
//            load/store (LS) requesters of the shared memory port.
// Ports    : if_valid   in  - fetch request pending
//            ls_valid   in  - load/store request pending
//            last_owner in  - owner of the previous transaction
//            grant_if   out - IF wins this cycle
//            grant_ls   out - LS wins this cycle
// Config   : ARB_RR_EN defined   -> round-robin on ties (previous loser wins)
//            ARB_RR_EN undefined -> fixed priority, LS over IF
// Revision : 1.0 - initial release
// ============================================================================
module arb_grant_sel
  import mem_port_arbiter_pkg::*;
(
  input  logic   if_valid,
  input  logic   ls_valid,
  input  owner_t last_owner,
  output logic   grant_if,
  output logic   grant_ls
);

`ifdef ARB_RR_EN
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (if_valid && ls_valid) begin
      // Tie: hand the port to whoever did not own the last transaction.
      grant_if = (last_owner == OWN_LS);
      grant_ls = (last_owner == OWN_IF);
    end else begin
      grant_if = if_valid;
      grant_ls = ls_valid;
    end
  end
`else
  // History is irrelevant under fixed priority.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    grant_ls = ls_valid;
    grant_if = if_valid && !ls_valid;
  end
`endif

endmodule : arb_grant_sel
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between instruction fetch (IF) and
//            load/store (LS). One transaction at a time:
//            grant -> issue -> wait for response -> return data to owner.
// Ports    : clk, rst (async, active-high)
//            if_req_valid/if_req_ready/if_addr        - fetch request
//            if_rsp_valid/if_rdata                    - fetch response
//            ls_req_valid/ls_req_ready/ls_addr/ls_wen/
//            ls_wdata/ls_wmask                        - load/store request
//            ls_rsp_valid/ls_rdata                    - load/store response
//            mem_req_valid/mem_req_ready/mem_addr/mem_wen/
//            mem_wdata/mem_wmask                      - memory request
//            mem_rsp_valid/mem_rdata                  - memory response
//            timeout_err                              - sticky timeout flag
// Config   : ARB_RR_EN selects round-robin arbitration (see arb_grant_sel).
//            TIMEOUT_CYCLES = 0 disables the response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  // fetch requester
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  // load/store requester
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  // memory side
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                timeout_err
);

  localparam int               CNT_W      = tcnt_width(TIMEOUT_CYCLES);
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  // Abort fires on the edge where the counter would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST   =
    TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state;
  state_t           state_nxt;
  owner_t           owner;
  owner_t           last_owner;
  logic [CNT_W-1:0] tcnt;
  logic             grant_if;
  logic             grant_ls;
  logic             accept;
  logic             tmo_hit;
  logic             rsp_done;
  logic             tmo_abort;

`ifdef ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_IF;
    end else if (accept) begin
      last_owner <= if_req_ready ? OWN_IF : OWN_LS;
    end
  end
`else
  assign last_owner = OWN_IF;
`endif

  arb_grant_sel u_grant_sel (
    .if_valid   (if_req_valid),
    .ls_valid   (ls_req_valid),
    .last_owner (last_owner),
    .grant_if   (grant_if),
    .grant_ls   (grant_ls)
  );

  assign accept  = if_req_ready || ls_req_ready;
  assign tmo_hit = TIMEOUT_EN && (state != IDLE) && (tcnt == CNT_LAST);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    rsp_done      = 1'b0;
    tmo_abort     = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so every output reads 0 while reset is held.
        if_req_ready = grant_if && !rst;
        ls_req_ready = grant_ls && !rst;
        if (if_req_ready || ls_req_ready) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_nxt = IDLE;
        end else if (mem_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A response arriving on the limit cycle beats the timeout.
        if (mem_rsp_valid) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Holding registers, response path, timeout counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner        <= OWN_IF;
      mem_addr     <= '0;
      mem_wen      <= 1'b0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
      tcnt         <= '0;
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if_rdata     <= '0;
      ls_rdata     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;

      if (if_req_ready) begin
        owner     <= OWN_IF;
        mem_addr  <= if_addr;
        mem_wen   <= 1'b0;
        mem_wdata <= '0;
        mem_wmask <= '0;
      end else if (ls_req_ready) begin
        owner     <= OWN_LS;
        mem_addr  <= ls_addr;
        mem_wen   <= ls_wen;
        mem_wdata <= ls_wdata;
        mem_wmask <= ls_wmask;
      end

      if (accept) begin
        tcnt <= '0;
      end else if (state != IDLE) begin
        tcnt <= tcnt + 1'b1;
      end

      // Aborted transactions and store acks return zero data.
      if (rsp_done || tmo_abort) begin
        if (owner == OWN_LS) begin
          ls_rsp_valid <= 1'b1;
          ls_rdata     <= (tmo_abort || mem_wen) ? '0 : mem_rdata;
        end else begin
          if_rsp_valid <= 1'b1;
          if_rdata     <= tmo_abort ? '0 : mem_rdata;
        end
      end

      if (tmo_abort) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter
//            (TIMEOUT_CYCLES = 8). Inputs change 1 time unit after the rising
//            edge; outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid;
  logic          if_req_ready;
  logic [AW-1:0] if_addr;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rdata;
  logic          ls_req_valid;
  logic          ls_req_ready;
  logic [AW-1:0] ls_addr;
  logic          ls_wen;
  logic [DW-1:0] ls_wdata;
  logic [MW-1:0] ls_wmask;
  logic          ls_rsp_valid;
  logic [DW-1:0] ls_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rdata;
  logic          timeout_err;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rdata      (if_rdata),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_addr       (ls_addr),
    .ls_wen        (ls_wen),
    .ls_wdata      (ls_wdata),
    .ls_wmask      (ls_wmask),
    .ls_rsp_valid  (ls_rsp_valid),
    .ls_rdata      (ls_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic exp_if_first;
  int   k;
  int   found;

  initial begin
`ifdef ARB_RR_EN
    exp_if_first = 1'b1;
`else
    exp_if_first = 1'b0;
`endif
    rst = 1'b1;
    if_req_valid = 1'b0; if_addr = '0;
    ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;

    // ---------------- reset state ----------------
    #2;
    check("rst_if_rdy",    if_req_ready, 0);
    check("rst_ls_rdy",    ls_req_ready, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_if_rsp",    if_rsp_valid, 0);
    check("rst_ls_rsp",    ls_rsp_valid, 0);
    check("rst_if_rdata",  if_rdata, 0);
    check("rst_ls_rdata",  ls_rdata, 0);
    check("rst_mem_addr",  mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    check("rst_tmo",       timeout_err, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // ---------------- spurious response in IDLE ----------------
    mem_rsp_valid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    sample();
    check("spur_mem_valid", mem_req_valid, 0);
    next_cycle();
    mem_rsp_valid = 1'b0;
    sample();
    check("spur_if_rsp",   if_rsp_valid, 0);
    check("spur_ls_rsp",   ls_rsp_valid, 0);
    check("spur_if_rdata", if_rdata, 0);
    check("spur_mem_valid2", mem_req_valid, 0);
    next_cycle();

    // ---------------- IF-only read, minimum latency ----------------
    if_req_valid = 1'b1; if_addr = 64'h8000_0000;              // c0
    sample();
    check("ifrd_if_rdy", if_req_ready, 1);
    check("ifrd_ls_rdy", ls_req_ready, 0);
    next_cycle();                                              // c1
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    ls_req_valid = 1'b1; ls_addr = 64'h1234;
    sample();
    check("ifrd_issue_valid", mem_req_valid, 1);
    check("ifrd_issue_addr",  mem_addr, 64'h8000_0000);
    check("ifrd_issue_wen",   mem_wen, 0);
    check("ifrd_busy_ls_rdy", ls_req_ready, 0);
    next_cycle();                                              // c2
    ls_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h0000_0013_0010_0073;
    sample();
    check("ifrd_wait_valid", mem_req_valid, 0);
    check("ifrd_rsp_early",  if_rsp_valid, 0);
    next_cycle();                                              // c3
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    sample();
    check("ifrd_rsp",     if_rsp_valid, 1);
    check("ifrd_rdata",   if_rdata, 64'h0000_0013_0010_0073);
    check("ifrd_ls_rsp",  ls_rsp_valid, 0);
    next_cycle();                                              // c4
    sample();
    check("ifrd_rsp_pulse", if_rsp_valid, 0);
    check("ifrd_rdata_hold", if_rdata, 64'h0000_0013_0010_0073);
    next_cycle();

    // ---------------- simultaneous requests: LS then IF ----------------
    if_req_valid = 1'b1; if_addr = 64'h8000_0004;              // c0
    ls_req_valid = 1'b1; ls_addr = 64'h8000_1000; ls_wen = 1'b0;
    sample();
    check("sim_ls_rdy", ls_req_ready, 1);
    check("sim_if_rdy", if_req_ready, 0);
    next_cycle();                                              // c1
    ls_req_valid = 1'b0; mem_req_ready = 1'b1;
    sample();
    check("sim_ls_addr",   mem_addr, 64'h8000_1000);
    check("sim_if_rdy_busy", if_req_ready, 0);
    next_cycle();                                              // c2
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h1111;
    next_cycle();                                              // c3
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    sample();
    check("sim_ls_rsp",   ls_rsp_valid, 1);
    check("sim_ls_rdata", ls_rdata, 64'h1111);
    check("sim_if_rsp0",  if_rsp_valid, 0);
    check("sim_b2b_if_rdy", if_req_ready, 1);
    next_cycle();                                              // c4
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    sample();
    check("sim_if_valid", mem_req_valid, 1);
    check("sim_if_addr",  mem_addr, 64'h8000_0004);
    next_cycle();                                              // c5
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h2222;
    next_cycle();                                              // c6
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    sample();
    check("sim_if_rsp",     if_rsp_valid, 1);
    check("sim_if_rdata",   if_rdata, 64'h2222);
    check("sim_ls_rsp0",    ls_rsp_valid, 0);
    check("sim_ls_rdata_hold", ls_rdata, 64'h1111);
    next_cycle();

    // ---------------- store with stalled memory ----------------
    ls_req_valid = 1'b1; ls_wen = 1'b1; ls_addr = 64'h8000_2000;  // c0
    ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
    sample();
    check("st_ls_rdy", ls_req_ready, 1);
    next_cycle();                                              // c1
    ls_req_valid = 1'b0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin                          // c1..c4
      sample();
      check("st_hold_ctl",   {mem_req_valid, mem_wen, mem_wmask}, {1'b1, 1'b1, 8'h0F});
      check("st_hold_wdata", mem_wdata, 64'hDEAD_BEEF);
      check("st_hold_addr",  mem_addr, 64'h8000_2000);
      next_cycle();
    end
    mem_req_ready = 1'b1;                                      // c5
    next_cycle();                                              // c6
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'hBAD0_BAD0;
    sample();
    check("st_rsp_early", ls_rsp_valid, 0);
    next_cycle();                                              // c7
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    sample();
    check("st_ls_rsp",   ls_rsp_valid, 1);
    check("st_ls_rdata", ls_rdata, 0);
    next_cycle();                                              // c8
    sample();
    check("st_rsp_pulse", ls_rsp_valid, 0);
    next_cycle();

    // ---------------- tie after an LS transaction ----------------
    if_req_valid = 1'b1; if_addr = 64'h8000_0008;
    ls_req_valid = 1'b1; ls_addr = 64'h8000_1008; ls_wen = 1'b0;
    sample();
    check("tie_if_rdy", if_req_ready, exp_if_first);
    check("tie_ls_rdy", ls_req_ready, !exp_if_first);
    next_cycle();
    if_req_valid = 1'b0; ls_req_valid = 1'b0; mem_req_ready = 1'b1;
    sample();
    check("tie_addr", mem_addr, exp_if_first ? 64'h8000_0008 : 64'h8000_1008);
    next_cycle();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h3333;
    next_cycle();
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    sample();
    check("tie_if_rsp", if_rsp_valid, exp_if_first);
    check("tie_ls_rsp", ls_rsp_valid, !exp_if_first);
    next_cycle();

    // ---------------- response on the limit cycle wins ----------------
    if_req_valid = 1'b1; if_addr = 64'h8000_4000;              // c0
    next_cycle();                                              // c1
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    next_cycle();                                              // c2
    mem_req_ready = 1'b0;
    repeat (5) next_cycle();                                   // c7
    sample();
    check("lim_no_rsp_c7", if_rsp_valid, 0);
    next_cycle();                                              // c8
    mem_rsp_valid = 1'b1; mem_rdata = 64'h5555;
    next_cycle();                                              // c9
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    sample();
    check("lim_if_rsp",   if_rsp_valid, 1);
    check("lim_if_rdata", if_rdata, 64'h5555);
    check("lim_tmo",      timeout_err, 0);
    next_cycle();

    // ---------------- timeout, memory never responds ----------------
    if_req_valid = 1'b1; if_addr = 64'h8000_5000;              // c0
    next_cycle();                                              // c1
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    sample();
    check("tmo_issue", mem_req_valid, 1);
    next_cycle();                                              // c2
    mem_req_ready = 1'b0;
    k = 2; found = 0;
    while (k <= 20 && found == 0) begin
      sample();
      if (if_rsp_valid) found = 1;
      else begin
        next_cycle();
        k++;
      end
    end
    check("tmo_cycle",     64'(k), 64'd9);
    check("tmo_if_rdata",  if_rdata, 0);
    check("tmo_err",       timeout_err, 1);
    check("tmo_mem_valid", mem_req_valid, 0);
    next_cycle();
    sample();
    check("tmo_rsp_pulse", if_rsp_valid, 0);
    next_cycle();
    // good LS load afterwards; error stays set
    ls_req_valid = 1'b1; ls_addr = 64'h8000_1010; ls_wen = 1'b0;
    next_cycle();
    ls_req_valid = 1'b0; mem_req_ready = 1'b1;
    next_cycle();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h6666;
    next_cycle();
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    sample();
    check("post_tmo_ls_rsp",   ls_rsp_valid, 1);
    check("post_tmo_ls_rdata", ls_rdata, 64'h6666);
    check("post_tmo_err",      timeout_err, 1);
    next_cycle();

    // ---------------- async reset while in WAIT ----------------
    if_req_valid = 1'b1; if_addr = 64'h8000_6000;              // c0
    next_cycle();                                              // c1
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    next_cycle();                                              // c2 (WAIT)
    mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_mem_valid", mem_req_valid, 0);
    check("arst_tmo",       timeout_err, 0);
    check("arst_ls_rdata",  ls_rdata, 0);
    check("arst_if_rdata",  if_rdata, 0);
    check("arst_mem_addr",  mem_addr, 0);
    sample();
    rst = 1'b0;
    next_cycle();                                              // late response
    mem_rsp_valid = 1'b1; mem_rdata = 64'h7777;
    next_cycle();
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    sample();
    check("arst_no_if_rsp", if_rsp_valid, 0);
    check("arst_no_ls_rsp", ls_rsp_valid, 0);
    check("arst_if_rdata2", if_rdata, 0);
    next_cycle();
    // normal transaction after reset
    if_req_valid = 1'b1; if_addr = 64'h8000_7000;
    sample();
    check("arst_next_rdy", if_req_ready, 1);
    next_cycle();
    if_req_valid = 1'b0; mem_req_ready = 1'b1;
    sample();
    check("arst_next_addr", mem_addr, 64'h8000_7000);
    next_cycle();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h8888;
    next_cycle();
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    sample();
    check("arst_next_rsp",   if_rsp_valid, 1);
    check("arst_next_rdata", if_rdata, 64'h8888);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
